// File: rtl/i2c_scl_stretch_gen_if.sv
// Bus bundle between the SCL/phase generator and its byte-FSM/pad neighbours.
// The master modport is the generator side. The slave modport is the consumer/pad side.
interface i2c_scl_stretch_gen_if;
    logic       ena;
    logic       scl_in;
    logic       scl_clk;
    logic       data_clk;
    logic [2:0] phase;
    logic       switch_range;
    logic       stretching;
    logic       timeout;

    modport master (
        input  ena,
        input  scl_in,
        output scl_clk,
        output data_clk,
        output phase,
        output switch_range,
        output stretching,
        output timeout
    );

    modport slave (
        output ena,
        output scl_in,
        input  scl_clk,
        input  data_clk,
        input  phase,
        input  switch_range,
        input  stretching,
        input  timeout
    );
endinterface

// File: rtl/i2c_scl_stretch_gen.sv
// I2C master SCL generator: four quarter phases of DIVIDER clks, with slave clock-stretch hold in HIGH_A.
// Optional stretch timeout is enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_scl_stretch_gen #(
    parameter int unsigned DIVIDER        = 3000,
    parameter int unsigned CHECK_POINT    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    i2c_scl_stretch_gen_if.master     bus
);

    localparam int unsigned CBITS = $clog2(DIVIDER);
    localparam int unsigned TBITS = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOW_A  = 3'd1;
    localparam logic [2:0] S_LOW_B  = 3'd2;
    localparam logic [2:0] S_HIGH_A = 3'd3;
    localparam logic [2:0] S_HIGH_B = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CBITS-1:0] r_qcnt;
    logic [CBITS-1:0] w_qcnt_nxt;
    logic [1:0]       r_sync;
    logic             r_scl_clk;
    logic             r_data_clk;
    logic             r_switch_range;
    logic             r_stretching;
    logic             w_scl_nxt;
    logic             w_data_nxt;
    logic             w_sw_nxt;
    logic             w_scl_sync;
    logic             w_qwrap;
    logic             w_check;
    logic             w_fire;
    logic             w_hold;

    assign w_scl_sync = r_sync[1];
    assign w_qwrap    = (r_qcnt == CBITS'(DIVIDER - 1));
    assign w_check    = (r_state == S_HIGH_A) && (r_qcnt == CBITS'(CHECK_POINT));
    // Timeout has priority over a release seen on the same clk
    assign w_hold     = w_check && !w_scl_sync && !w_fire;

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [TBITS-1:0] r_tcnt;
    logic             r_timeout;

    assign w_fire = w_check && (r_tcnt == TBITS'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tcnt    <= w_hold ? (r_tcnt + TBITS'(1)) : '0;
            r_timeout <= w_fire;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic [TBITS-1:0] w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = TBITS'(TIMEOUT_CYCLES);
    assign w_fire               = 1'b0;
    assign bus.timeout          = 1'b0;
`endif

    // Next state/count and next-state output decode
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_scl_nxt   = 1'b1;
        w_data_nxt  = 1'b0;
        w_sw_nxt    = 1'b0;

        if (r_state == S_IDLE) begin
            if (bus.ena) begin
                w_state_nxt = S_LOW_A;
                w_qcnt_nxt  = '0;
            end
        end else if (!w_hold) begin
            if (w_qwrap) begin
                w_qcnt_nxt = '0;
                case (r_state)
                    S_LOW_A:  w_state_nxt = S_LOW_B;
                    S_LOW_B:  w_state_nxt = S_HIGH_A;
                    S_HIGH_A: w_state_nxt = S_HIGH_B;
                    S_HIGH_B: w_state_nxt = bus.ena ? S_LOW_A : S_IDLE;
                    default:  w_state_nxt = S_IDLE;
                endcase
            end else begin
                w_qcnt_nxt = r_qcnt + CBITS'(1);
            end
        end

        case (w_state_nxt)
            S_LOW_A: begin
                w_scl_nxt = 1'b0;
            end
            S_LOW_B: begin
                w_scl_nxt  = 1'b0;
                w_data_nxt = 1'b1;
            end
            S_HIGH_A: begin
                w_data_nxt = 1'b1;
                w_sw_nxt   = 1'b1;
            end
            default: begin
                w_scl_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_qcnt         <= '0;
            r_sync         <= 2'b11;
            r_scl_clk      <= 1'b1;
            r_data_clk     <= 1'b0;
            r_switch_range <= 1'b0;
            r_stretching   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_qcnt         <= w_qcnt_nxt;
            r_sync         <= {r_sync[0], bus.scl_in};
            r_scl_clk      <= w_scl_nxt;
            r_data_clk     <= w_data_nxt;
            r_switch_range <= w_sw_nxt;
            r_stretching   <= w_hold;
        end
    end

    assign bus.phase        = r_state;
    assign bus.scl_clk      = r_scl_clk;
    assign bus.data_clk     = r_data_clk;
    assign bus.switch_range = r_switch_range;
    assign bus.stretching   = r_stretching;

endmodule
